// File: rtl/logic_unit_pkg.sv
// Shared definitions for the sequential logic unit.
//   OP_*    : 3-bit opcode encodings (fully decoded, all eight are legal)
//   state_e : control FSM states
package logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;  // ~a, b ignored
  localparam logic [2:0] OP_PASS = 3'b111;  // a, b ignored

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/logic_slice.sv
// Combinational slice gate: applies one of the eight bitwise operations to
// a SLICE-bit chunk of the operands.
//   a, b : operand slices
//   op   : opcode (see logic_unit_pkg)
//   y    : slice result
module logic_slice
  import logic_unit_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [2:0]       op,
  output logic [SLICE-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_NOT:  y = ~a;
      default: y = a;  // OP_PASS
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit. Operands are accepted over a valid/ready
// handshake, then processed SLICE bits per clock through a single reused
// slice gate; after N = W/SLICE clocks the result and its zero / parity /
// sign flags are presented over a second valid/ready handshake.
//   clk, rst_b          : clock, async active-low reset
//   in_valid, in_ready  : input handshake (ready only in IDLE)
//   in_0, in_1, op      : operands and opcode
//   out_valid, out_ready: output handshake
//   result, zero, parity, neg : result word and flags
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int W     = 64,
  parameter int SLICE = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_0,
  input  logic [W-1:0] in_1,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         parity,
  output logic         neg
);

  localparam int N  = W / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((SLICE < 1) || (W % SLICE != 0)) begin : g_bad_param
    $error("logic_unit_seq: W must be a non-zero multiple of SLICE");
  end

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            zero_q, zero_d, par_q, par_d, ov_q, ov_d;
  logic [SLICE-1:0] y;
  logic [W-1:0]    y_ext;

  logic_slice #(.SLICE(SLICE)) u_slice (
    .a  (a_q[SLICE-1:0]),
    .b  (b_q[SLICE-1:0]),
    .op (op_q),
    .y  (y)
  );

  // Slice result enters at the MSB end so the word is aligned after N shifts.
  assign y_ext = W'(y);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    par_d   = par_q;
    ov_d    = ov_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_0;
          b_d     = in_1;
          op_d    = op;
          res_d   = '0;
          zero_d  = 1'b1;
          par_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d    = a_q >> SLICE;
        b_d    = b_q >> SLICE;
        res_d  = (res_q >> SLICE) | (y_ext << (W - SLICE));
        zero_d = zero_q & (y == '0);
        par_d  = par_q ^ (^y);
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          ov_d    = 1'b1;
        end
      end
      S_DONE: begin
        // Result and flags hold; only out_valid drops on the handshake.
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_AND;
      res_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      par_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      par_q   <= par_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = ov_q;
  assign result    = res_q;
  assign zero      = zero_q;
  assign parity    = par_q;
  assign neg       = res_q[W-1];

endmodule
